nios_mult_pipe: RTL and testbench

- Parametrised, pipelined integer multiplier for the Nios II custom datapath.
- Successor to the fixed 16x16 partial-product cell. It adds the following:
  - configurable operand width;
  - operand-sign modes that give the full MUL/MULXUU/MULXSU/MULXSS result;
  - sign correction and partial-product summation inside the block;
  - valid/tag tracking through a stallable 2-stage pipeline.
- Sits between the E-stage operand muxes and the M/W-stage result mux.

---
 rtl/nios_mult_pipe.sv | 115 +++++++++++
 tb/tb_nios_mult_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_mult_pipe.sv
// Two-stage pipelined integer multiplier for the Nios II custom datapath.
// Unsigned half-word partial products plus a sign-correction term give MUL/MULXUU/MULXSU/MULXSS.
module nios_mult_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int HALF_W = DATA_W / 2;
    localparam int FULL_W = 2 * DATA_W;

    function automatic logic [DATA_W-1:0] umul_half(input logic [HALF_W-1:0] x,
                                                    input logic [HALF_W-1:0] y);
        return {{HALF_W{1'b0}}, x} * {{HALF_W{1'b0}}, y};
    endfunction

    // Sign handling is folded into one subtraction of corr in the upper word,
    // so all four partial products stay unsigned.
    function automatic logic [FULL_W-1:0] sum_products(input logic [DATA_W-1:0] pll,
                                                       input logic [DATA_W-1:0] plh,
                                                       input logic [DATA_W-1:0] phl,
                                                       input logic [DATA_W-1:0] phh,
                                                       input logic [DATA_W:0]   corr);
        logic [DATA_W:0]   mid;
        logic [FULL_W-1:0] acc;
        mid = {1'b0, plh} + {1'b0, phl};
        acc = {{DATA_W{1'b0}}, pll};
        acc = acc + ({{(DATA_W-1){1'b0}}, mid} << HALF_W);
        acc = acc + {phh, {DATA_W{1'b0}}};
        acc = acc - FULL_W'({corr, {DATA_W{1'b0}}});
        return acc;
    endfunction

    function automatic logic [DATA_W-1:0] select_result(input logic [1:0]        op,
                                                        input logic [FULL_W-1:0] full);
        return (op == 2'b00) ? full[DATA_W-1:0] : full[FULL_W-1:DATA_W];
    endfunction

    logic [HALF_W-1:0] al, ah, bl, bh;
    logic              sa, sb;
    logic [DATA_W:0]   corr_a, corr_b;

    assign al = in_src1[HALF_W-1:0];
    assign ah = in_src1[DATA_W-1:HALF_W];
    assign bl = in_src2[HALF_W-1:0];
    assign bh = in_src2[DATA_W-1:HALF_W];
    assign sa = in_op[1];
    assign sb = in_op[1] & in_op[0];

    assign corr_a = (sa && in_src1[DATA_W-1]) ? {1'b0, in_src2} : '0;
    assign corr_b = (sb && in_src2[DATA_W-1]) ? {1'b0, in_src1} : '0;

    logic [DATA_W-1:0] pll_p1, plh_p1, phl_p1, phh_p1;
    logic [DATA_W:0]   corr_p1;
    logic [1:0]        op_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic              vld_p1;

    // Stage 1: partial products and sign correction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pll_p1  <= '0;
            plh_p1  <= '0;
            phl_p1  <= '0;
            phh_p1  <= '0;
            corr_p1 <= '0;
            op_p1   <= '0;
            tag_p1  <= '0;
            vld_p1  <= 1'b0;
        end else if (en) begin
            pll_p1  <= umul_half(al, bl);
            plh_p1  <= umul_half(al, bh);
            phl_p1  <= umul_half(ah, bl);
            phh_p1  <= umul_half(ah, bh);
            corr_p1 <= corr_a + corr_b;
            op_p1   <= in_op;
            tag_p1  <= in_tag;
            vld_p1  <= in_valid;
        end
    end

    logic [DATA_W-1:0] result_p2;
    logic [TAG_W-1:0]  tag_p2;
    logic              vld_p2;

    // Stage 2: summation and word select
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_p2 <= '0;
            tag_p2    <= '0;
            vld_p2    <= 1'b0;
        end else if (en) begin
            result_p2 <= select_result(op_p1,
                                       sum_products(pll_p1, plh_p1, phl_p1, phh_p1, corr_p1));
            tag_p2    <= tag_p1;
            vld_p2    <= vld_p1;
        end
    end

    assign out_valid  = vld_p2;
    assign out_result = result_p2;
    assign out_tag    = tag_p2;

endmodule

// File: tb/tb_nios_mult_pipe.sv
// Bench for nios_mult_pipe: 32-bit vector table, stall/reset sequences, and a random
// mixed-stall run on 32-bit and 16-bit instances against a 64-bit reference product.
module tb_nios_mult_pipe;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        en;

    logic        iv32, ov32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, res32;
    logic [4:0]  tag32, otag32;

    logic        iv16, ov16;
    logic [1:0]  op16;
    logic [15:0] a16, b16, res16;
    logic [4:0]  tag16, otag16;

    exp_t q32[$];
    exp_t q16[$];
    vec_t vt[12];

    int checks;
    int errors;
    int en_edges;

    logic        pv32, pv16;
    logic [31:0] pr32;
    logic [15:0] pr16;
    logic [4:0]  pt32, pt16;

    nios_mult_pipe #(.DATA_W(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .en(en),
        .in_valid(iv32), .in_op(op32), .in_src1(a32), .in_src2(b32), .in_tag(tag32),
        .out_valid(ov32), .out_result(res32), .out_tag(otag32)
    );

    nios_mult_pipe #(.DATA_W(16), .TAG_W(5)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .en(en),
        .in_valid(iv16), .in_op(op16), .in_src1(a16), .in_src2(b16), .in_tag(tag16),
        .out_valid(ov16), .out_result(res16), .out_tag(otag16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
        logic [63:0] mask, a64, b64, p;
        mask = (64'd1 << w) - 64'd1;
        a64  = {32'b0, a} & mask;
        b64  = {32'b0, b} & mask;
        if (op[1] && a64[w-1]) a64 = a64 | ~mask;
        if (op == 2'b11 && b64[w-1]) b64 = b64 | ~mask;
        p = a64 * b64;
        return (op == 2'b00) ? 32'(p & mask) : 32'((p >> w) & mask);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (enabled edge %0d)", name, got, exp, en_edges);
        end
    endtask

    task automatic drive32(input logic v, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
        iv32 = v; op32 = op; a32 = a; b32 = b; tag32 = tag;
        if (v && en) q32.push_back('{exp, tag, en_edges + 2});
    endtask

    task automatic drive16(input logic v, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [4:0] tag, input logic [31:0] exp);
        iv16 = v; op16 = op; a16 = a; b16 = b; tag16 = tag;
        if (v && en) q16.push_back('{exp, tag, en_edges + 2});
    endtask

    task automatic idle();
        drive32(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0);
        drive16(1'b0, 2'b00, 16'h0, 16'h0, 5'd0, 32'h0);
    endtask

    task automatic step();
        logic e;
        logic exp_v;
        exp_t x;
        e = en;
        @(posedge clk);
        if (e) en_edges++;
        #1;
        if (e) begin
            exp_v = (q32.size() > 0) && (q32[0].due == en_edges);
            chk("valid32", {31'b0, ov32}, {31'b0, exp_v});
            if (exp_v) begin
                x = q32.pop_front();
                chk("result32", res32, x.res);
                chk("tag32", {27'b0, otag32}, {27'b0, x.tag});
            end
            exp_v = (q16.size() > 0) && (q16[0].due == en_edges);
            chk("valid16", {31'b0, ov16}, {31'b0, exp_v});
            if (exp_v) begin
                x = q16.pop_front();
                chk("result16", {16'b0, res16}, x.res);
                chk("tag16", {27'b0, otag16}, {27'b0, x.tag});
            end
        end else begin
            chk("stall_valid32", {31'b0, ov32}, {31'b0, pv32});
            chk("stall_result32", res32, pr32);
            chk("stall_tag32", {27'b0, otag32}, {27'b0, pt32});
            chk("stall_valid16", {31'b0, ov16}, {31'b0, pv16});
            chk("stall_result16", {16'b0, res16}, {16'b0, pr16});
        end
        pv32 = ov32; pr32 = res32; pt32 = otag32;
        pv16 = ov16; pr16 = res16; pt16 = otag16;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [15:0] sa16, sb16;
        logic [4:0]  rtag;
        logic        rv;

        checks = 0; errors = 0; en_edges = 0;
        pv32 = 1'b0; pr32 = '0; pt32 = '0;
        pv16 = 1'b0; pr16 = '0; pt16 = '0;

        vt[0]  = '{2'b00, 32'h0001_0003, 32'h0002_0005, 5'd7,  32'h000B_000F};
        vt[1]  = '{2'b01, 32'h0001_0003, 32'h0002_0005, 5'd8,  32'h0000_0002};
        vt[2]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
        vt[3]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000};
        vt[4]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
        vt[5]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0001};
        vt[6]  = '{2'b11, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000};
        vt[7]  = '{2'b11, 32'h8000_0000, 32'h0000_0001, 5'd6,  32'hFFFF_FFFF};
        vt[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000};
        vt[9]  = '{2'b00, 32'h0000_0003, 32'h0000_0005, 5'd10, 32'h0000_000F};
        vt[10] = '{2'b11, 32'h0000_0002, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFF};
        vt[11] = '{2'b01, 32'h0000_0002, 32'hFFFF_FFFF, 5'd12, 32'h0000_0001};

        reset_n = 1'b0;
        en = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) step();
        chk("reset_result32", res32, 32'h0);
        chk("reset_tag32", {27'b0, otag32}, 32'h0);
        chk("reset_result16", {16'b0, res16}, 32'h0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            drive32(1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].exp);
            step();
        end
        idle();
        for (int i = 0; i < 3; i++) step();

        // Stall right after capture; an offered op during the stall must not be taken.
        drive32(1'b1, 2'b00, 32'd3, 32'd5, 5'd2, 32'd15);
        step();
        en = 1'b0;
        drive32(1'b1, 2'b00, 32'd7, 32'd7, 5'd9, 32'd49);
        for (int i = 0; i < 4; i++) step();
        en = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) step();

        // Stall while a result is being presented; it must hold, then continue in order.
        drive32(1'b1, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20,
                ref_mul(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 32));
        step();
        drive32(1'b1, 2'b10, 32'hDEAD_BEEF, 32'h0000_1000, 5'd21,
                ref_mul(2'b10, 32'hDEAD_BEEF, 32'h0000_1000, 32));
        step();
        en = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) step();
        en = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Asynchronous reset between edges with two operations in flight.
        drive32(1'b1, 2'b00, 32'h0000_1111, 32'h0000_0003, 5'd17, 32'h0000_3333);
        step();
        drive32(1'b1, 2'b11, 32'hFFFF_FFFE, 32'h0000_0004, 5'd18, 32'hFFFF_FFFF);
        step();
        idle();
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_valid", {31'b0, ov32}, 32'h0);
        chk("async_reset_result", res32, 32'h0);
        chk("async_reset_tag", {27'b0, otag32}, 32'h0);
        q32.delete();
        q16.delete();
        pv32 = 1'b0; pr32 = '0; pt32 = '0;
        pv16 = 1'b0; pr16 = '0; pt16 = '0;
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step();

        drive16(1'b1, 2'b10, 16'h8000, 16'hFFFF, 5'd3, 32'h0000_8000);
        step();
        idle();

        for (int i = 0; i < 2000; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            rv   = ($urandom_range(0, 4) != 0);
            rop  = 2'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            rtag = 5'($urandom);
            drive32(rv, rop, ra, rb, rtag, ref_mul(rop, ra, rb, 32));
            rv   = ($urandom_range(0, 4) != 0);
            rop  = 2'($urandom_range(0, 3));
            sa16 = 16'($urandom);
            sb16 = 16'($urandom);
            if ($urandom_range(0, 7) == 0) sa16 = 16'h8000;
            if ($urandom_range(0, 7) == 0) sb16 = 16'hFFFF;
            rtag = 5'($urandom);
            drive16(rv, rop, sa16, sb16, rtag, ref_mul(rop, {16'b0, sa16}, {16'b0, sb16}, 16));
            step();
        end
        en = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) step();

        chk("leftover32", q32.size(), 32'd0);
        chk("leftover16", q16.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
